// File: rtl/cd_clk_meter.sv
// cd_clk_meter - measures the half-period of a divided clock (clkin) in clk
// cycles, i.e. recovers the divider limit that produced it.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         asynchronous reset, active-high
//   clkin       divided clock under measurement (may be asynchronous to clk)
//   half_period last measured half-period in clk cycles
//   meas_valid  one-cycle pulse, half_period updated this cycle
//   locked      LOCK_COUNT consecutive equal measurements seen
//   timeout     no clkin edge for TIMEOUT_CYCLES cycles, sticky until next edge
//
// Build option:
//   CD_METER_TOLERANCE_EN  when defined, measurements within +/-1 of the previous
//                          half_period count as equal for the lock decision.

module cd_clk_meter #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned LOCK_COUNT     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clkin,
   output logic [WIDTH-1:0] half_period,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [WIDTH-1:0] TMO       = WIDTH'(TIMEOUT_CYCLES);
   localparam logic [3:0]       MATCH_MAX = 4'(LOCK_COUNT - 1);

   typedef enum logic {
      WAIT_EDGE,
      MEASURE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   edge_det;
   logic [WIDTH-1:0]       count;
   logic [WIDTH-1:0]       count_inc;
   logic [3:0]             match_cnt;
   logic                   first_meas;
   logic                   same;

   // Saturating increment keeps count from ever wrapping.
   always_comb begin
      count_inc = (count >= TMO) ? TMO : count + WIDTH'(1);
   end

   always_comb begin
`ifdef CD_METER_TOLERANCE_EN
      if (count >= half_period)
         same = ((count - half_period) <= WIDTH'(1));
      else
         same = ((half_period - count) <= WIDTH'(1));
`else
      same = (count == half_period);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync        <= '0;
         prev        <= 1'b0;
         edge_det    <= 1'b0;
         count       <= '0;
         match_cnt   <= '0;
         first_meas  <= 1'b1;
         half_period <= '0;
         meas_valid  <= 1'b0;
         locked      <= 1'b0;
         timeout     <= 1'b0;
         state       <= WAIT_EDGE;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], clkin};
         prev       <= sync[SYNC_STAGES-1];
         // Registered edge flag: either polarity of the synchronised level.
         edge_det   <= sync[SYNC_STAGES-1] ^ prev;
         meas_valid <= 1'b0;
         count      <= edge_det ? WIDTH'(1) : count_inc;

         case (state)
            WAIT_EDGE: begin
               if (edge_det) begin
                  timeout    <= 1'b0;
                  match_cnt  <= '0;
                  first_meas <= 1'b1;
                  state      <= MEASURE;
               end
            end

            MEASURE: begin
               if (edge_det) begin
                  // An edge wins over a timeout landing on the same cycle.
                  half_period <= count;
                  meas_valid  <= 1'b1;
                  first_meas  <= 1'b0;
                  if (!first_meas && same) begin
                     if (match_cnt < MATCH_MAX)
                        match_cnt <= match_cnt + 4'd1;
                     if ((match_cnt + 4'd1) >= MATCH_MAX)
                        locked <= 1'b1;
                  end else begin
                     match_cnt <= '0;
                     locked    <= 1'b0;
                  end
               end else if (count_inc == TMO) begin
                  timeout   <= 1'b1;
                  locked    <= 1'b0;
                  match_cnt <= '0;
                  state     <= WAIT_EDGE;
               end
            end

            default: state <= WAIT_EDGE;
         endcase
      end
   end

endmodule

// File: tb/tb_cd_clk_meter.sv
module tb_cd_clk_meter;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned LOCKN = 4;
   localparam int unsigned TMO   = 64;
   localparam int          D     = SYNC + 1;
`ifdef CD_METER_TOLERANCE_EN
   localparam int          TOL   = 1;
`else
   localparam int          TOL   = 0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             clkin;
   logic [WIDTH-1:0] half_period;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   int checks = 0;
   int errors = 0;

   cd_clk_meter #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC),
      .LOCK_COUNT(LOCKN),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clkin(clkin),
      .half_period(half_period),
      .meas_valid(meas_valid),
      .locked(locked),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   // ---------------- clkin generator (divider model) ----------------
   bit gen_en = 0, gen_was_en = 0, alt_en = 0, rand_en = 0, alt_sel = 0;
   int cur_L = 5, next_L = 5, alt_a = 6, alt_b = 7, ph = 0;

   initial begin
      clkin = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (gen_en) begin
            if (!gen_was_en) ph = 0;
            ph++;
            if (ph >= cur_L) begin
               clkin = ~clkin;
               ph = 0;
               if (rand_en) begin
                  if ($urandom_range(0, 2) == 0)
                     cur_L = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 12))
                                                         : int'($urandom_range(55, 70));
               end else if (alt_en) begin
                  alt_sel = !alt_sel;
                  cur_L = alt_sel ? alt_b : alt_a;
               end else begin
                  cur_L = next_L;
               end
            end
         end
         gen_was_en = gen_en;
      end
   end

   // ---------------- behavioural reference model ----------------
   // Edges are clkin level changes seen D clk edges late; measurements are the
   // distance between consecutive edges, lock is a run-length of close values.
   bit hist [0:D+1];
   bit mdl_ok = 0, armed = 0;
   int cyc = 0, last_ev = 0, run = 0;
   int m_hp = 0;
   bit m_mv = 0, m_lk = 0, m_to = 0;

   function automatic bit close_enough(input int a, input int b);
      int d;
      d = (a > b) ? a - b : b - a;
      return (d <= TOL);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         for (int i = 0; i <= D + 1; i++) hist[i] = 1'b0;
         armed = 0; run = 0; m_hp = 0; m_mv = 0; m_lk = 0; m_to = 0;
         mdl_ok = 1;
      end else begin
         for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = clkin;
         m_mv = 0;
         if (hist[D] != hist[D+1]) begin
            if (!armed) begin
               armed = 1; m_to = 0; run = 0;
            end else begin
               int d;
               d = cyc - last_ev;
               run = (run > 0 && close_enough(d, m_hp)) ? run + 1 : 1;
               m_hp = d;
               m_mv = 1;
               m_lk = (run >= LOCKN);
            end
            last_ev = cyc;
         end else if (armed && (cyc - last_ev + 1) == TMO) begin
            m_to = 1; m_lk = 0; run = 0; armed = 0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("half_period", int'(half_period), rst ? 0 : m_hp);
         chk("meas_valid",  int'(meas_valid),  rst ? 0 : int'(m_mv));
         chk("locked",      int'(locked),      rst ? 0 : int'(m_lk));
         chk("timeout",     int'(timeout),     rst ? 0 : int'(m_to));
      end
   end

   task automatic wait_valid(input int budget);
      int n = 0;
      @(negedge clk);
      while (!meas_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!meas_valid) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: no meas_valid within %0d cycles", budget);
      end
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int n;
      bit hit;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_half_period", int'(half_period), 0);
      chk("rst_meas_valid",  int'(meas_valid), 0);
      chk("rst_locked",      int'(locked), 0);
      chk("rst_timeout",     int'(timeout), 0);
      @(posedge clk); #3 rst = 1'b0;

      // L=5: lock on the 4th valid
      gen_en = 1;
      wait_valid(40);
      chk("l5_first_hp", int'(half_period), 5);
      chk("l5_first_unlocked", int'(locked), 0);
      wait_valid(20); wait_valid(20);
      chk("l5_third_unlocked", int'(locked), 0);
      wait_valid(20);
      chk("l5_fourth_hp", int'(half_period), 5);
      chk("l5_fourth_locked", int'(locked), 1);

      // switch to L=3
      next_L = 3;
      hit = 0;
      for (int i = 0; i < 4 && !hit; i++) begin
         wait_valid(20);
         if (half_period != 5) hit = 1;
      end
      chk("l3_first_hp", int'(half_period), 3);
      chk("l3_first_unlocked", int'(locked), 0);
      wait_valid(20); wait_valid(20);
      chk("l3_third_unlocked", int'(locked), 0);
      wait_valid(20);
      chk("l3_fourth_locked", int'(locked), 1);

      // L=1: continuous meas_valid
      next_L = 1;
      hit = 0;
      for (int i = 0; i < 8 && !hit; i++) begin
         wait_valid(20);
         if (half_period == 1) hit = 1;
      end
      wait_valid(5); wait_valid(5); wait_valid(5);
      chk("l1_locked", int'(locked), 1);
      chk("l1_hp", int'(half_period), 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("l1_valid_held", int'(meas_valid), 1);
      end

      // timeout after lock at L=5
      next_L = 5;
      hit = 0;
      for (int i = 0; i < 8 && !hit; i++) begin
         wait_valid(20);
         if (half_period == 5) hit = 1;
      end
      wait_valid(20); wait_valid(20); wait_valid(20);
      chk("to_pre_locked", int'(locked), 1);
      gen_en = 0;
      n = 0;
      for (int i = 0; i < 200 && !timeout; i++) begin
         @(negedge clk);
         if (meas_valid) n = 0; else n++;
      end
      chk("to_cycles_after_valid", n, int'(TMO) - 1);
      chk("to_timeout", int'(timeout), 1);
      chk("to_unlocked", int'(locked), 0);
      chk("to_hp_kept", int'(half_period), 5);
      gen_en = 1;
      n = 0;
      while (timeout && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("to_cleared", int'(timeout), 0);
      chk("to_arm_no_valid", int'(meas_valid), 0);
      wait_valid(20);
      chk("to_next_hp", int'(half_period), 5);

      // reset mid-half-period while locked at L=7
      next_L = 7;
      hit = 0;
      for (int i = 0; i < 8 && !hit; i++) begin
         wait_valid(20);
         if (half_period == 7) hit = 1;
      end
      wait_valid(20); wait_valid(20); wait_valid(20);
      chk("r7_locked", int'(locked), 1);
      n = 0;
      while (!(clkin == 1'b0 && ph == 2) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("r7_phase_found", int'(clkin == 1'b0 && ph == 2), 1);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("r7_async_hp", int'(half_period), 0);
      chk("r7_async_valid", int'(meas_valid), 0);
      chk("r7_async_locked", int'(locked), 0);
      chk("r7_async_timeout", int'(timeout), 0);
      @(posedge clk); @(posedge clk); #3 rst = 1'b0;
      wait_valid(60);
      chk("r7_first_hp", int'(half_period), 7);
      chk("r7_first_unlocked", int'(locked), 0);

      // jitter: 6/7 alternation, then 6/8
      alt_en = 1; alt_a = 6; alt_b = 7;
      repeat (6) wait_valid(20);
      chk("tol_67_locked", int'(locked), TOL);
      alt_b = 8;
      repeat (5) wait_valid(20);
      chk("tol_68_unlocked", int'(locked), 0);

      // randomized divisors with occasional stalls
      alt_en = 0; rand_en = 1;
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(50, 150)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            gen_en = 0;
            repeat ($urandom_range(40, 90)) @(negedge clk);
            gen_en = 1;
         end
      end
      rand_en = 0;
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
